// File: rtl/clk_burst_ctl.sv
// Gated clock-enable controller: stop/run/single/burst, parity-error stop, EBOX sync divider.
module clk_burst_ctl #(
  parameter int unsigned NCHAN    = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned NSRC     = 4,
  parameter int unsigned SYNC_DIV = 4
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic [2:0]       func_h,
  input  logic             func_go_h,
  input  logic [CNT_W-1:0] burst_cnt_h,
  input  logic [NCHAN-1:0] chan_en_h,
  input  logic [NSRC-1:0]  par_err_h,
  input  logic [NSRC-1:0]  par_chk_en_h,
  input  logic             err_stop_en_h,
  output logic [NCHAN-1:0] clk_en_h,
  output logic             ebox_sync_h,
  output logic             running_h,
  output logic             burst_busy_h,
  output logic             error_stop_h,
  output logic [NSRC-1:0]  err_src_h,
  output logic [CNT_W-1:0] burst_left_h
);

  localparam int unsigned    PH_W    = (SYNC_DIV > 1) ? $clog2(SYNC_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYNC_DIV - 1);

  typedef enum logic [2:0] {
    ST_STOP, ST_RUN, ST_SINGLE, ST_BURST, ST_ERRSTOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] left, left_nx;
  logic [NSRC-1:0]  src, src_nx;
  logic [PH_W-1:0]  phase;
  logic [NSRC-1:0]  masked;
  logic             tick;
  logic             err;

  always_comb begin
    tick   = (state == ST_RUN) || (state == ST_SINGLE) || (state == ST_BURST);
    masked = par_err_h & par_chk_en_h;
    err    = tick & err_stop_en_h & (|masked);
  end

  // Precedence: autonomous progression, then strobe override, then error wins.
  always_comb begin
    state_nx = state;
    left_nx  = left;
    src_nx   = src;

    case (state)
      ST_SINGLE: state_nx = ST_STOP;
      ST_BURST: begin
        if (left == CNT_W'(1)) begin
          state_nx = ST_STOP;
          left_nx  = '0;
        end else begin
          left_nx = left - CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (state == ST_ERRSTOP) begin
      if (func_go_h && (func_h == 3'd5)) begin
        state_nx = ST_STOP;
        src_nx   = '0;
      end
    end else if (func_go_h) begin
      case (func_h)
        3'd1: begin state_nx = ST_STOP;   left_nx = '0; end
        3'd2: begin state_nx = ST_RUN;    left_nx = '0; end
        3'd3: begin state_nx = ST_SINGLE; left_nx = '0; end
        3'd4: begin
          if (burst_cnt_h != '0) begin
            state_nx = ST_BURST;
            left_nx  = burst_cnt_h;
          end
        end
        default: ;
      endcase
    end

    if (err) begin
      state_nx = ST_ERRSTOP;
      src_nx   = masked;
      left_nx  = '0;
    end
  end

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      state <= ST_STOP;
      left  <= '0;
      src   <= '0;
      phase <= '0;
    end else begin
      state <= state_nx;
      left  <= left_nx;
      src   <= src_nx;
      if (tick) begin
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
    end
  end

  assign clk_en_h     = chan_en_h & {NCHAN{tick}};
  assign ebox_sync_h  = tick & (phase == '0);
  assign running_h    = tick;
  assign burst_busy_h = (state == ST_BURST);
  assign error_stop_h = (state == ST_ERRSTOP);
  assign err_src_h    = src;
  assign burst_left_h = left;

endmodule

// File: tb/tb_clk_burst_ctl.sv
module tb_clk_burst_ctl;

  localparam int unsigned NCHAN    = 8;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NSRC     = 4;
  localparam int unsigned SYNC_DIV = 4;

  localparam int M_STOP = 0, M_RUN = 1, M_SINGLE = 2, M_BURST = 3, M_ERR = 4;

  typedef struct packed {
    logic [NCHAN-1:0] clk_en;
    logic             sync;
    logic             running;
    logic             busy;
    logic             errstop;
    logic [NSRC-1:0]  src;
    logic [CNT_W-1:0] left;
  } obs_t;

  logic             clk_h = 1'b0;
  logic             reset_h;
  logic [2:0]       func_h;
  logic             func_go_h;
  logic [CNT_W-1:0] burst_cnt_h;
  logic [NCHAN-1:0] chan_en_h;
  logic [NSRC-1:0]  par_err_h;
  logic [NSRC-1:0]  par_chk_en_h;
  logic             err_stop_en_h;
  logic [NCHAN-1:0] clk_en_h;
  logic             ebox_sync_h;
  logic             running_h;
  logic             burst_busy_h;
  logic             error_stop_h;
  logic [NSRC-1:0]  err_src_h;
  logic [CNT_W-1:0] burst_left_h;

  clk_burst_ctl #(
    .NCHAN(NCHAN), .CNT_W(CNT_W), .NSRC(NSRC), .SYNC_DIV(SYNC_DIV)
  ) dut (
    .clk_h(clk_h), .reset_h(reset_h), .func_h(func_h), .func_go_h(func_go_h),
    .burst_cnt_h(burst_cnt_h), .chan_en_h(chan_en_h), .par_err_h(par_err_h),
    .par_chk_en_h(par_chk_en_h), .err_stop_en_h(err_stop_en_h),
    .clk_en_h(clk_en_h), .ebox_sync_h(ebox_sync_h), .running_h(running_h),
    .burst_busy_h(burst_busy_h), .error_stop_h(error_stop_h),
    .err_src_h(err_src_h), .burst_left_h(burst_left_h)
  );

  always #5 clk_h = ~clk_h;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t exp_q[$];

  // reference model: operating mode, remaining burst ticks, total ticks issued
  int              m_mode;
  int              m_left;
  int              m_ticks;
  logic [NSRC-1:0] m_src;

  function automatic obs_t actual();
    obs_t a;
    a.clk_en  = clk_en_h;
    a.sync    = ebox_sync_h;
    a.running = running_h;
    a.busy    = burst_busy_h;
    a.errstop = error_stop_h;
    a.src     = err_src_h;
    a.left    = burst_left_h;
    return a;
  endfunction

  task automatic model_reset();
    m_mode  = M_STOP;
    m_left  = 0;
    m_ticks = 0;
    m_src   = '0;
  endtask

  task automatic check_now(input string name, input obs_t exp);
    obs_t act;
    act = actual();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: record what this cycle must show, advance the model, cross the edge.
  task automatic step();
    obs_t e;
    bit tk;
    logic [NSRC-1:0] msk;
    tk = (m_mode == M_RUN) || (m_mode == M_SINGLE) || (m_mode == M_BURST);
    e.clk_en  = tk ? chan_en_h : '0;
    e.sync    = tk && ((m_ticks % SYNC_DIV) == 0);
    e.running = tk;
    e.busy    = (m_mode == M_BURST);
    e.errstop = (m_mode == M_ERR);
    e.src     = m_src;
    e.left    = CNT_W'(m_left);
    exp_q.push_back(e);

    msk = par_err_h & par_chk_en_h;
    if (tk) m_ticks++;
    if (tk && err_stop_en_h && (msk != '0)) begin
      m_mode = M_ERR; m_src = msk; m_left = 0;
    end else if (m_mode == M_ERR) begin
      if (func_go_h && func_h == 3'd5) begin
        m_mode = M_STOP; m_src = '0;
      end
    end else if (func_go_h && func_h == 3'd1) begin
      m_mode = M_STOP; m_left = 0;
    end else if (func_go_h && func_h == 3'd2) begin
      m_mode = M_RUN; m_left = 0;
    end else if (func_go_h && func_h == 3'd3) begin
      m_mode = M_SINGLE; m_left = 0;
    end else if (func_go_h && func_h == 3'd4 && burst_cnt_h != '0) begin
      m_mode = M_BURST; m_left = int'(burst_cnt_h);
    end else if (m_mode == M_SINGLE) begin
      m_mode = M_STOP;
    end else if (m_mode == M_BURST) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = M_STOP;
    end

    @(posedge clk_h);
    #1;
    func_go_h = 1'b0;
    par_err_h = '0;
  endtask

  task automatic strobe(input logic [2:0] f);
    func_h    = f;
    func_go_h = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_h);
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = actual();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    obs_t zero;
    zero = '0;
    reset_h = 1'b1;
    func_h = '0; func_go_h = 1'b0; burst_cnt_h = '0; chan_en_h = '0;
    par_err_h = '0; par_chk_en_h = '0; err_stop_en_h = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_h);
    #1;
    chan_en_h = 8'h0F;
    check_now("reset_state", zero);
    reset_h = 1'b0;

    // run with sync every 4 ticks, then stop
    strobe(3'd2);
    idle(10);
    strobe(3'd1);
    idle(2);

    // burst of 3
    burst_cnt_h = 8'd3;
    strobe(3'd4);
    idle(5);

    // two singles separated by idle cycles
    strobe(3'd3);
    idle(2);
    strobe(3'd3);
    idle(2);

    // masked parity error while running
    strobe(3'd2);
    idle(2);
    par_chk_en_h = 4'b0101; err_stop_en_h = 1'b1; par_err_h = 4'b0111;
    step();
    idle(1);
    strobe(3'd2);
    idle(1);
    strobe(3'd5);
    idle(2);

    // burst 10 cut short by stop on the fourth tick
    burst_cnt_h = 8'd10;
    strobe(3'd4);
    idle(3);
    strobe(3'd1);
    idle(2);

    // error and run strobe in the same cycle during a burst
    burst_cnt_h = 8'd5;
    strobe(3'd4);
    idle(1);
    par_err_h = 4'b0001;
    strobe(3'd2);
    idle(2);
    strobe(3'd5);
    idle(1);

    // zero-length burst does nothing
    burst_cnt_h = 8'd0;
    strobe(3'd4);
    idle(2);

    // asynchronous reset in the middle of a burst
    burst_cnt_h = 8'd20;
    strobe(3'd4);
    idle(3);
    #2 reset_h = 1'b1;
    #1 check_now("async_reset_mid_burst", zero);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk_h);
    #1 reset_h = 1'b0;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      func_h        = 3'($urandom_range(0, 7));
      func_go_h     = ($urandom_range(0, 2) == 0);
      burst_cnt_h   = CNT_W'($urandom_range(0, 12));
      chan_en_h     = NCHAN'($urandom);
      par_chk_en_h  = NSRC'($urandom);
      err_stop_en_h = ($urandom_range(0, 1) == 1);
      par_err_h     = ($urandom_range(0, 15) == 0) ? NSRC'($urandom) : '0;
      step();
    end

    @(negedge clk_h);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
